// File: rtl/arrow_event_queue_pkg.sv
// Shared defaults and event packing helpers for the DDR arrow event queue.
package arrow_event_queue_pkg;

  localparam int unsigned DEF_NUM_BUTTONS = 4;
  localparam int unsigned DEF_FIFO_DEPTH  = 8;
  localparam int unsigned DEF_STAMP_BITS  = 16;
  localparam int unsigned DEF_BTN_W       = $clog2(DEF_NUM_BUTTONS);

  // Packed event layout, MSB first: {button, release, stamp}
  function automatic int unsigned event_width(input int unsigned btn_w,
                                              input int unsigned stamp_bits);
    return btn_w + 1 + stamp_bits;
  endfunction

endpackage

// File: rtl/arrow_event_queue_sync_fifo.sv
// Synchronous FIFO with registered storage, occupancy count and full/empty flags.
module arrow_event_queue_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/arrow_event_queue.sv
// Timestamps debounced button edges, serialises them through per-button slots
// into an ordered event FIFO read over valid/ready; dropped edges set a sticky flag.
module arrow_event_queue
  import arrow_event_queue_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS = DEF_NUM_BUTTONS,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned STAMP_BITS  = DEF_STAMP_BITS,
  localparam int unsigned BTN_W = $clog2(NUM_BUTTONS),
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] rise,
  input  logic [NUM_BUTTONS-1:0] fall,
  input  logic                   tick,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [BTN_W-1:0]       ev_button,
  output logic                   ev_release,
  output logic [STAMP_BITS-1:0]  ev_stamp,
  output logic [CNT_W-1:0]       ev_count,
  input  logic                   ovf_clear,
  output logic                   overflow
);

  localparam int unsigned EV_W = event_width(BTN_W, STAMP_BITS);

  logic [STAMP_BITS-1:0]  stamp;
  logic [NUM_BUTTONS-1:0] slot_valid;
  logic [NUM_BUTTONS-1:0] slot_rel;
  logic [STAMP_BITS-1:0]  slot_stamp [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] slot_valid_nxt;
  logic [NUM_BUTTONS-1:0] slot_rel_nxt;
  logic [STAMP_BITS-1:0]  slot_stamp_nxt [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] drain;
  logic [NUM_BUTTONS-1:0] drop;
  logic [BTN_W-1:0]       grant;
  logic                   any_valid;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic                   ovf_set;
  logic [EV_W-1:0]        wdata;
  logic [EV_W-1:0]        rdata;

  always_ff @(posedge clock) begin
    if (reset)     stamp <= '0;
    else if (tick) stamp <= stamp + STAMP_BITS'(1);
  end

  // Fixed priority: lowest-index pending slot wins
  always_comb begin
    grant     = '0;
    any_valid = |slot_valid;
    for (int i = int'(NUM_BUTTONS) - 1; i >= 0; i--) begin
      if (slot_valid[i]) grant = BTN_W'(i);
    end
  end

  assign pop  = ev_valid & ev_ready;
  assign push = any_valid & (~full | pop);

  // Slot update: capture into a free or draining slot, otherwise drop
  always_comb begin
    slot_valid_nxt = slot_valid;
    slot_rel_nxt   = slot_rel;
    slot_stamp_nxt = slot_stamp;
    drain          = '0;
    drop           = '0;
    for (int i = 0; i < int'(NUM_BUTTONS); i++) begin
      drain[i] = push && (grant == BTN_W'(i));
      if (rise[i] || fall[i]) begin
        if (slot_valid[i] && !drain[i]) begin
          drop[i] = 1'b1;
        end else begin
          slot_valid_nxt[i] = 1'b1;
          slot_rel_nxt[i]   = fall[i];
          slot_stamp_nxt[i] = stamp;
        end
      end else if (drain[i]) begin
        slot_valid_nxt[i] = 1'b0;
      end
    end
    ovf_set = (|drop) | (|(rise & fall));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid <= '0;
      slot_rel   <= '0;
      for (int i = 0; i < int'(NUM_BUTTONS); i++) slot_stamp[i] <= '0;
    end else begin
      slot_valid <= slot_valid_nxt;
      slot_rel   <= slot_rel_nxt;
      slot_stamp <= slot_stamp_nxt;
    end
  end

  // Setting wins over a same-cycle clear
  always_ff @(posedge clock) begin
    if (reset)          overflow <= 1'b0;
    else if (ovf_set)   overflow <= 1'b1;
    else if (ovf_clear) overflow <= 1'b0;
  end

  assign wdata = {grant, slot_rel[grant], slot_stamp[grant]};

  arrow_event_queue_sync_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (ev_count)
  );

  assign ev_valid                          = ~empty;
  assign {ev_button, ev_release, ev_stamp} = rdata;

endmodule

// File: tb/tb_arrow_event_queue.sv
// Directed self-checking bench for arrow_event_queue (4 buttons, depth 8, 16-bit stamps).
module tb_arrow_event_queue;

  logic        clock;
  logic        reset;
  logic [3:0]  rise;
  logic [3:0]  fall;
  logic        tick;
  logic        ev_valid;
  logic        ev_ready;
  logic [1:0]  ev_button;
  logic        ev_release;
  logic [15:0] ev_stamp;
  logic [3:0]  ev_count;
  logic        ovf_clear;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  arrow_event_queue dut (
    .clock      (clock),
    .reset      (reset),
    .rise       (rise),
    .fall       (fall),
    .tick       (tick),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_button  (ev_button),
    .ev_release (ev_release),
    .ev_stamp   (ev_stamp),
    .ev_count   (ev_count),
    .ovf_clear  (ovf_clear),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Head view packed as {valid, button, release, stamp}
  function automatic logic [31:0] ev(input logic v, input logic [1:0] b,
                                     input logic r, input logic [15:0] s);
    return 32'({v, b, r, s});
  endfunction

  function automatic logic [31:0] head();
    return 32'({ev_valid, ev_button, ev_release, ev_stamp});
  endfunction

  // One clock edge with the given pulses; inputs change #1 after the edge
  task automatic cyc(input logic [3:0] r, input logic [3:0] f, input logic t);
    rise = r;
    fall = f;
    tick = t;
    @(posedge clock);
    #1;
    rise = '0;
    fall = '0;
    tick = 1'b0;
  endtask

  logic [31:0] exp_q [10];
  logic [3:0]  onehot;

  initial begin
    reset = 1'b1; rise = '0; fall = '0; tick = 1'b0; ev_ready = 1'b0; ovf_clear = 1'b0;
    cyc('0, '0, 1'b0);
    cyc('0, '0, 1'b1);
    reset = 1'b0;
    check("reset_head", head(), ev(0, 0, 0, 0));
    check("reset_count", 32'(ev_count), 0);
    check("reset_ovf", 32'(overflow), 0);

    // Single press at stamp 5
    repeat (5) cyc('0, '0, 1'b1);
    cyc(4'b0100, '0, 1'b0);
    check("single_lat", 32'(ev_valid), 0);
    cyc('0, '0, 1'b0);
    check("single_head", head(), ev(1, 2, 0, 5));
    check("single_count", 32'(ev_count), 1);
    ev_ready = 1'b1;
    cyc('0, '0, 1'b0);
    check("single_pop_count", 32'(ev_count), 0);
    check("single_pop_head", head(), ev(0, 0, 0, 0));

    // Simultaneous presses serialise by index with a shared stamp
    cyc(4'b1011, '0, 1'b0);
    check("simul_lat", 32'(ev_count), 0);
    cyc('0, '0, 1'b0);
    check("simul_b0", head(), ev(1, 0, 0, 5));
    cyc('0, '0, 1'b0);
    check("simul_b1", head(), ev(1, 1, 0, 5));
    cyc('0, '0, 1'b0);
    check("simul_b3", head(), ev(1, 3, 0, 5));
    cyc('0, '0, 1'b0);
    check("simul_empty", 32'(ev_count), 0);

    // Backpressure: nine edges, stamps 5..13
    ev_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      onehot = 4'b0001 << (k % 4);
      if (((k / 4) % 2) == 0) cyc(onehot, '0, 1'b1);
      else                    cyc('0, onehot, 1'b1);
      exp_q[k] = ev(1, 2'(k % 4), 1'((k / 4) % 2), 16'(5 + k));
    end
    cyc('0, '0, 1'b0);
    check("bp_count_full", 32'(ev_count), 8);
    check("bp_ovf_clean", 32'(overflow), 0);
    check("bp_head_held", head(), exp_q[0]);
    cyc('0, 4'b0001, 1'b0);
    check("bp_second_edge_ovf", 32'(overflow), 1);
    ovf_clear = 1'b1;
    cyc('0, '0, 1'b0);
    ovf_clear = 1'b0;
    check("ovf_clear", 32'(overflow), 0);

    // Slot drop with FIFO full (stamp is now 14)
    cyc(4'b0010, '0, 1'b0);
    check("drop_first_ok", 32'(overflow), 0);
    cyc('0, 4'b0010, 1'b0);
    check("drop_ovf", 32'(overflow), 1);
    ovf_clear = 1'b1;
    cyc('0, 4'b0010, 1'b0);
    check("drop_set_wins", 32'(overflow), 1);
    cyc('0, '0, 1'b0);
    ovf_clear = 1'b0;
    check("drop_cleared", 32'(overflow), 0);
    exp_q[9] = ev(1, 1, 0, 14);

    // Release backpressure: held slot events follow the FIFO contents in order
    ev_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      check($sformatf("drain_%0d", j), head(), exp_q[j]);
      cyc('0, '0, 1'b0);
    end
    check("drain_empty", 32'(ev_count), 0);
    check("drain_valid", 32'(ev_valid), 0);

    // Stamp wrap: advance 14 -> 16'hFFFF
    tick = 1'b1;
    repeat (65521) @(posedge clock);
    #1;
    tick = 1'b0;
    cyc(4'b1000, '0, 1'b1);
    cyc('0, 4'b1000, 1'b0);
    check("wrap_ffff", head(), ev(1, 3, 0, 16'hFFFF));
    cyc('0, '0, 1'b0);
    check("wrap_zero_refill", head(), ev(1, 3, 1, 0));
    cyc('0, '0, 1'b0);
    check("wrap_empty", 32'(ev_count), 0);

    // Pointer wrap: 20 push/pop pairs, stamps 0..19
    for (int k = 0; k <= 20; k++) begin
      onehot = 4'b0001 << (k % 4);
      if (k == 20)                 cyc('0, '0, 1'b0);
      else if (((k / 4) % 2) == 0) cyc(onehot, '0, 1'b1);
      else                         cyc('0, onehot, 1'b1);
      if (k >= 1) begin
        check($sformatf("ptr_%0d", k - 1), head(),
              ev(1, 2'((k - 1) % 4), 1'(((k - 1) / 4) % 2), 16'(k - 1)));
        check($sformatf("ptr_cnt_%0d", k - 1), 32'(ev_count), 1);
      end
    end
    cyc('0, '0, 1'b0);
    check("ptr_empty", 32'(ev_count), 0);

    // Reset mid-operation (stamp is now 20)
    ev_ready = 1'b0;
    cyc(4'b1111, '0, 1'b1);
    cyc('0, '0, 1'b0);
    cyc(4'b1000, '0, 1'b0);
    cyc(4'b0001, '0, 1'b0);
    check("mid_count", 32'(ev_count), 3);
    check("mid_ovf", 32'(overflow), 1);
    reset = 1'b1;
    cyc(4'b0010, '0, 1'b1);
    reset = 1'b0;
    check("rst_head", head(), ev(0, 0, 0, 0));
    check("rst_count", 32'(ev_count), 0);
    check("rst_ovf", 32'(overflow), 0);
    cyc(4'b0001, '0, 1'b0);
    check("rst_slots_clear", 32'(ev_valid), 0);
    cyc('0, '0, 1'b0);
    check("rst_stamp0", head(), ev(1, 0, 0, 0));
    check("rst_count1", 32'(ev_count), 1);
    ev_ready = 1'b1;
    cyc('0, '0, 1'b0);
    check("rst_pop", 32'(ev_count), 0);

    // Rise and fall together: fall wins and flags overflow
    cyc(4'b0100, 4'b0100, 1'b0);
    check("both_ovf", 32'(overflow), 1);
    cyc('0, '0, 1'b0);
    check("both_fall_wins", head(), ev(1, 2, 1, 0));
    cyc('0, '0, 1'b0);
    check("both_empty", 32'(ev_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
